spi_cmd_decoder: RTL and testbench

//   Consumes 24-bit words from the SPI slave (done pulse + dout) and buffers them in a small FIFO.

---
 rtl/spi_cmd_decoder.sv | 117 +++++++++++
 tb/tb_spi_cmd_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder.sv
// Buffers 24-bit SPI command words in a small FIFO and executes maze-map commands
// against a cell register file; returns a registered status/readback word.
module spi_cmd_decoder #(
  parameter int CELLS      = 20,
  parameter int AW         = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          done,
  input  logic [23:0]   word_in,
  output logic [23:0]   resp_word,
  input  logic [AW-1:0] vga_addr,
  output logic [7:0]    vga_cell,
  output logic [7:0]    robot_pos,
  output logic          busy
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

  state_t        state, state_nx;
  logic [23:0]   fifo [FIFO_DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, push, ovf_evt;
  logic [23:0]   head;
  logic [19:0]   cmd_q;
  logic [3:0]    op;
  logic [7:0]    addr, data;
  logic          addr_ok, bad;
  logic [7:0]    cells [CELLS];
  logic [AW-1:0] clr_idx;
  logic [7:0]    rd_addr, rd_data;
  logic [3:0]    bad_cnt;
  logic          ovf;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop     = (state == IDLE) && !empty;
  // a full FIFO still takes the word if the head leaves on the same edge
  assign push    = done && (!full || pop);
  assign ovf_evt = done && full && !pop;
  assign head    = fifo[rd_ptr[PW-1:0]];
  assign busy    = (state != IDLE) || !empty;

  assign op      = cmd_q[19:16];
  assign addr    = cmd_q[15:8];
  assign data    = cmd_q[7:0];
  assign addr_ok = addr < 8'(CELLS);
  assign bad     = (op > 4'd5) || (((op == 4'd1) || (op == 4'd3)) && !addr_ok);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!empty) state_nx = EXEC;
      EXEC:    state_nx = (op == 4'd2) ? CLEAR : IDLE;
      CLEAR:   if (clr_idx == AW'(CELLS - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_q     <= '0;
      clr_idx   <= '0;
      rd_addr   <= '0;
      rd_data   <= '0;
      bad_cnt   <= '0;
      ovf       <= 1'b0;
      robot_pos <= '0;
      vga_cell  <= '0;
      resp_word <= 24'h000001;
      for (int i = 0; i < CELLS; i++) cells[i] <= 8'h00;
    end else begin
      if (push) begin
        fifo[wr_ptr[PW-1:0]] <= word_in;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        cmd_q  <= {head[23:12], head[7:0]};
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (state == EXEC) begin
        case (op)
          4'd1: if (addr_ok) cells[addr[AW-1:0]] <= data;
          4'd2: clr_idx <= '0;
          4'd3: if (addr_ok) begin
            rd_addr <= addr;
            rd_data <= cells[addr[AW-1:0]];
          end
          4'd4: robot_pos <= data;
          4'd5: begin
            bad_cnt <= '0;
            ovf     <= 1'b0;
          end
          default: ;
        endcase
        if (bad && (bad_cnt != 4'hF)) bad_cnt <= bad_cnt + 4'd1;
      end
      if (state == CLEAR) begin
        cells[clr_idx] <= 8'h00;
        clr_idx        <= clr_idx + AW'(1);
      end
      // placed after the ACKERR clear so a same-edge overflow wins
      if (ovf_evt) ovf <= 1'b1;
      vga_cell  <= (int'(vga_addr) < CELLS) ? cells[vga_addr] : 8'h00;
      resp_word <= {rd_addr, rd_data, bad_cnt, ovf, busy, 2'b01};
    end
  end
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench: a timeline reference model predicts every output each cycle,
// and a negedge monitor pops and compares; directed checks cover the key scenarios.
module tb_spi_cmd_decoder;
  localparam int CELLS = 20;
  localparam int AW = 5;
  localparam int DEPTH = 4;

  logic clk = 0, rst = 1, done = 0, busy;
  logic [23:0] word_in = '0, resp_word;
  logic [AW-1:0] vga_addr = '0;
  logic [7:0] vga_cell, robot_pos;

  spi_cmd_decoder #(.CELLS(CELLS), .AW(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .done(done), .word_in(word_in), .resp_word(resp_word),
    .vga_addr(vga_addr), .vga_cell(vga_cell), .robot_pos(robot_pos), .busy(busy));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] resp;
    logic [7:0]  vga;
    logic [7:0]  pos;
    logic        busy;
  } exp_t;

  exp_t sbq[$];
  exp_t ee, me;
  int n_chk = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a command popped at edge t acts at t+1; the next pop may
  // happen at t+2, or t+2+CELLS for CLEAR, whose zeroing sweeps one cell per edge.
  logic [23:0] mq[$];
  logic [7:0]  m_cells[CELLS];
  logic [23:0] m_cmd;
  logic [7:0]  m_rd_addr, m_rd_data, m_pos;
  int m_bad, next_pop, exec_at, clr_from;
  logic m_ovf, m_busy, pop_ok, accept;

  task automatic m_reset();
    mq.delete();
    foreach (m_cells[i]) m_cells[i] = 8'h00;
    m_rd_addr = 0; m_rd_data = 0; m_pos = 0; m_bad = 0; m_ovf = 0; m_busy = 0;
    next_pop = 0; exec_at = -1; clr_from = -1000;
  endtask

  task automatic m_exec(input logic [23:0] w);
    int op = int'(w[23:20]);
    int a = int'(w[19:12]);
    if (op >= 6 || ((op == 1 || op == 3) && a >= CELLS)) begin
      if (m_bad < 15) m_bad++;
    end else if (op == 1) m_cells[a] = w[7:0];
    else if (op == 2) clr_from = cyc + 1;
    else if (op == 3) begin m_rd_addr = w[19:12]; m_rd_data = m_cells[a]; end
    else if (op == 4) m_pos = w[7:0];
    else if (op == 5) begin m_bad = 0; m_ovf = 0; end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_reset();
      ee = '{resp: 24'h000001, vga: 8'h00, pos: 8'h00, busy: 1'b0};
    end else begin
      ee.resp = {m_rd_addr, m_rd_data, 4'(m_bad), m_ovf, m_busy, 2'b01};
      ee.vga = (int'(vga_addr) < CELLS) ? m_cells[vga_addr] : 8'h00;
      if (exec_at == cyc) m_exec(m_cmd);
      if (cyc >= clr_from && cyc < clr_from + CELLS) m_cells[cyc - clr_from] = 8'h00;
      pop_ok = (cyc >= next_pop) && (mq.size() > 0);
      accept = done && (mq.size() < DEPTH || pop_ok);
      if (done && !accept) m_ovf = 1'b1;
      if (pop_ok) begin
        m_cmd = mq.pop_front();
        exec_at = cyc + 1;
        next_pop = cyc + 2 + ((m_cmd[23:20] == 4'd2) ? CELLS : 0);
      end
      if (accept) mq.push_back(word_in);
      m_busy = (cyc + 1 < next_pop) || (mq.size() > 0);
      ee.pos = m_pos;
      ee.busy = m_busy;
    end
    cyc++;
    sbq.push_back(ee);
  end

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      chk("sb_resp_word", 32'(resp_word), 32'(me.resp));
      chk("sb_vga_cell", 32'(vga_cell), 32'(me.vga));
      chk("sb_robot_pos", 32'(robot_pos), 32'(me.pos));
      chk("sb_busy", 32'(busy), 32'(me.busy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [23:0] w);
    done = 1'b1;
    word_in = w;
    tick();
    done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic scan_cells(input string name, input logic [7:0] cell0);
    for (int i = 0; i < CELLS; i++) begin
      vga_addr = AW'(i);
      tick();
      chk(name, 32'(vga_cell), (i == 0) ? 32'(cell0) : 32'h0);
    end
  endtask

  initial begin
    int n;
    logic [3:0] op;
    idle(2);
    rst = 0;
    chk("reset_resp", 32'(resp_word), 32'h000001);
    chk("reset_busy", 32'(busy), 32'h0);

    // write then VGA readback
    put(24'h1050A5);
    idle(3);
    vga_addr = 5;
    tick();
    chk("vga_cell5", 32'(vga_cell), 32'hA5);

    // readback through resp_word
    put(24'h305000);
    idle(4);
    chk("read_resp", 32'(resp_word), 32'h05A501);

    // five back-to-back words fit; a longer burst overflows
    for (int i = 0; i < 5; i++) put({4'h1, 8'(10 + i), 4'h0, 8'(8'h50 + i)});
    idle(16);
    chk("burst5_no_ovf", 32'(resp_word[3]), 32'h0);
    for (int i = 0; i < 10; i++) put({4'h0, 20'($urandom)});
    idle(24);
    chk("burst10_ovf", 32'(resp_word[3]), 32'h1);
    put(24'h500000);
    idle(5);
    chk("ackerr_ovf", 32'(resp_word[3]), 32'h0);

    // bad ops and saturation
    put(24'h114077);
    idle(1);
    put(24'hF00000);
    idle(5);
    chk("bad_cnt2", 32'(resp_word[7:4]), 32'h2);
    for (int i = 0; i < 17; i++) begin
      put({4'(6 + (i % 10)), 20'($urandom)});
      idle(1);
    end
    idle(5);
    chk("bad_cnt_sat", 32'(resp_word[7:4]), 32'hF);
    put(24'h500000);
    idle(4);

    // CLEAR followed by a write to cell 0
    for (int i = 0; i < CELLS; i++) begin
      put({4'h1, 8'(i), 4'h0, 8'($urandom_range(1, 255))});
      idle(1);
    end
    put(24'h200000);
    put(24'h10003C);
    n = 1;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("clear_busy_min", 32'(n >= CELLS + 3), 32'h1);
    chk("clear_busy_max", 32'(n <= CELLS + 4), 32'h1);
    scan_cells("after_clear", 8'h3C);

    // reset in the middle of CLEAR with words queued
    put(24'h1000AA);
    idle(1);
    put(24'h200000);
    idle(4);
    put(24'h100011);
    put(24'h101022);
    rst = 1;
    tick();
    rst = 0;
    chk("midclr_rst_resp", 32'(resp_word), 32'h000001);
    chk("midclr_rst_busy", 32'(busy), 32'h0);
    idle(3);
    chk("midclr_rst_idle", 32'(busy), 32'h0);
    scan_cells("after_rst", 8'h00);

    // randomized traffic, checked by the scoreboard
    for (int i = 0; i < 600; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd2 && $urandom_range(0, 3) != 0) op = 4'd1;
      done = ($urandom_range(0, 2) == 0);
      word_in = {op, 8'($urandom_range(0, 24)), 12'($urandom)};
      vga_addr = AW'($urandom_range(0, 31));
      tick();
    end
    done = 0;
    idle(60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
